// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked integer execution unit.
//
// Executes RV32I/RV64I register-register, register-immediate, LUI and
// AUIPC operations in one cycle.  With ALU_PIPE_MULDIV_EN defined the
// M-extension multiply/divide operations run iteratively, one bit per
// cycle over XLEN cycles.  Without it they report as unsupported.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   flush               synchronous kill of in-flight op and held result
//   in_valid/in_ready   operation handshake from the reservation station
//   instr_name          operation (structures::instr_name_t)
//   data_1, data_2      source operands rs1, rs2
//   immediate, address  sign-extended immediate, instruction address
//   tag                 destination tag carried with the operation
//   out_valid/out_ready result handshake towards the CDB arbiter
//   result, out_tag     offered result value and tag
//   out_illegal         offered result came from an unsupported op
//   busy                iterative operation in progress

package structures;
  typedef enum logic [5:0] {
    ADD, ADDI, SUB, SLT, SLTI, SLTU, SLTIU, XOR, XORI, OR, ORI, AND, ANDI,
    SLL, SLLI, SRL, SRLI, SRA, SRAI, LUI, AUIPC,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    LW, SW, BEQ, JAL, ECALL
  } instr_name_t;
endpackage

module alu_pipe
  import structures::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  instr_name_t          instr_name,
  input  logic [XLEN-1:0]      data_1,
  input  logic [XLEN-1:0]      data_2,
  input  logic [XLEN-1:0]      immediate,
  input  logic [XLEN-1:0]      address,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_illegal,
  output logic                 busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt_r;
  logic [SHW-1:0]  shamt_i;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            accept;

  assign shamt_r = data_2[SHW-1:0];
  assign shamt_i = immediate[SHW-1:0];
  assign accept  = in_valid && in_ready;

`ifdef ALU_PIPE_MULDIV_EN
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  instr_name_t       op_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   mcand;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;        // {high, low}: product, or {remainder, quotient}
  logic [SHW-1:0]    cnt;
  logic              start_iter;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              is_mul_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shl;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
`else
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign busy     = 1'b0;
`endif

  // Single-cycle datapath; also resolves the divide special cases so they
  // never enter the iterative path.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
`ifdef ALU_PIPE_MULDIV_EN
    start_iter = 1'b0;
`endif
    case (instr_name)
      ADD:   alu_res = data_1 + data_2;
      ADDI:  alu_res = data_1 + immediate;
      SUB:   alu_res = data_1 - data_2;
      SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(data_1) < $signed(data_2)};
      SLTI:  alu_res = {{(XLEN-1){1'b0}}, $signed(data_1) < $signed(immediate)};
      SLTU:  alu_res = {{(XLEN-1){1'b0}}, data_1 < data_2};
      SLTIU: alu_res = {{(XLEN-1){1'b0}}, data_1 < immediate};
      XOR:   alu_res = data_1 ^ data_2;
      XORI:  alu_res = data_1 ^ immediate;
      OR:    alu_res = data_1 | data_2;
      ORI:   alu_res = data_1 | immediate;
      AND:   alu_res = data_1 & data_2;
      ANDI:  alu_res = data_1 & immediate;
      SLL:   alu_res = data_1 << shamt_r;
      SLLI:  alu_res = data_1 << shamt_i;
      SRL:   alu_res = data_1 >> shamt_r;
      SRLI:  alu_res = data_1 >> shamt_i;
      SRA:   alu_res = $signed(data_1) >>> shamt_r;
      SRAI:  alu_res = $signed(data_1) >>> shamt_i;
      LUI:   alu_res = immediate;
      AUIPC: alu_res = address + immediate;
`ifdef ALU_PIPE_MULDIV_EN
      MUL, MULH, MULHSU, MULHU: start_iter = 1'b1;
      DIV, REM: begin
        if (data_2 == '0)
          alu_res = (instr_name == DIV) ? '1 : data_1;
        else if (data_1 == MOST_NEG && data_2 == '1)
          alu_res = (instr_name == DIV) ? data_1 : '0;
        else
          start_iter = 1'b1;
      end
      DIVU, REMU: begin
        if (data_2 == '0)
          alu_res = (instr_name == DIVU) ? '1 : data_1;
        else
          start_iter = 1'b1;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MULDIV_EN
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (instr_name)
      MULH, DIV, REM: begin
        a_sgn = data_1[XLEN-1];
        b_sgn = data_2[XLEN-1];
      end
      MULHSU:  a_sgn = data_1[XLEN-1];
      default: ;
    endcase
  end

  assign a_mag    = a_sgn ? -data_1 : data_1;
  assign b_mag    = b_sgn ? -data_2 : data_2;
  assign is_mul_q = op_q inside {MUL, MULH, MULHSU, MULHU};

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring division: dividend bits shift from the low half into the
  // partial remainder; quotient bits fill the low half from the right.
  assign div_shl  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_shl - {1'b0, mcand};
  assign div_next = div_diff[XLEN] ? {div_shl[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod = (sa_q ^ sb_q) ? -acc : acc;
  assign quo  = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = rem;
    case (op_q)
      MUL:                 fix_res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           fix_res = quo;
      default:             fix_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      busy        <= 1'b0;
      op_q        <= ADD;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else if (flush) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            out_tag <= tag;
            if (start_iter) begin
              state <= ITER;
              busy  <= 1'b1;
              op_q  <= instr_name;
              sa_q  <= a_sgn;
              sb_q  <= b_sgn;
              mcand <= b_mag;
              acc   <= {{XLEN{1'b0}}, a_mag};
              cnt   <= '0;
            end else begin
              result      <= alu_res;
              out_illegal <= alu_ill;
              out_valid   <= 1'b1;
            end
          end
        end
        ITER: begin
          acc <= is_mul_q ? mul_next : div_next;
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(XLEN-1))
            state <= FIX;
        end
        FIX: begin
          result      <= fix_res;
          out_illegal <= 1'b0;
          out_valid   <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Without the M extension the FSM is permanently IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      result      <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        result      <= alu_res;
        out_tag     <= tag;
        out_illegal <= alu_ill;
        out_valid   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (XLEN=32, TAG_WIDTH=6).
// Table-driven single-cycle vectors plus hand-written sequences for
// reset, back-pressure, flush and (with ALU_PIPE_MULDIV_EN) iterative ops.

module tb_alu_pipe;
  import structures::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 6;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready;
  logic            out_valid, out_ready, out_illegal, busy;
  instr_name_t     instr_name;
  logic [XLEN-1:0] data_1, data_2, immediate, address, result;
  logic [TW-1:0]   tag, out_tag;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(XLEN), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_name(instr_name), .data_1(data_1), .data_2(data_2),
    .immediate(immediate), .address(address), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .out_illegal(out_illegal), .busy(busy)
  );

  typedef struct {
    instr_name_t     op;
    logic [XLEN-1:0] d1, d2, imm, addr;
    logic [TW-1:0]   tg;
    logic [XLEN-1:0] exp;
    logic            ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(instr_name_t op, logic [XLEN-1:0] d1, logic [XLEN-1:0] d2,
                              logic [XLEN-1:0] imm, logic [XLEN-1:0] addr, logic [TW-1:0] tg,
                              logic [XLEN-1:0] exp, logic ill);
    vec_t v;
    v.op = op; v.d1 = d1; v.d2 = d2; v.imm = imm; v.addr = addr;
    v.tg = tg; v.exp = exp; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input instr_name_t op, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [XLEN-1:0] imm, input logic [XLEN-1:0] addr, input logic [TW-1:0] tg);
    instr_name = op; data_1 = d1; data_2 = d2; immediate = imm; address = addr; tag = tg;
    in_valid = 1'b1;
  endtask

  // Offers one op for a single edge; returns 1 ns after that edge.
  task automatic issue(input instr_name_t op, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [XLEN-1:0] imm, input logic [TW-1:0] tg);
    drive(op, d1, d2, imm, '0, tg);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

`ifdef ALU_PIPE_MULDIV_EN
  task automatic run_iter(input string name, input instr_name_t op, input logic [XLEN-1:0] d1,
                          input logic [XLEN-1:0] d2, input logic [XLEN-1:0] exp);
    int lat;
    logic ir_bad;
    lat = 0;
    ir_bad = 1'b0;
    issue(op, d1, d2, '0, 6'h2A);
    chk({name, "_busy"}, 64'(busy), 64'd1);
    for (int c = 1; c <= 40; c++) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(XLEN + 1));
    chk({name, "_result"}, 64'(result), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'h2A);
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
    chk({name, "_in_ready_low"}, 64'(ir_bad), 64'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr_name = ADD; data_1 = '0; data_2 = '0; immediate = '0; address = '0; tag = '0;

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0; #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-stream: a held result vanishes immediately
    out_ready = 1'b0;
    issue(ADD, 32'd20, 32'd22, '0, 6'd9);
    chk("pre_rst_result", 64'(result), 64'd42);
    reset = 1'b1; #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_out_tag", 64'(out_tag), 64'd0);
    reset = 1'b0; out_ready = 1'b1; #1;

    // Single-cycle vector table
    vecs.push_back(mk(ADD,   32'hFFFF_FFFF, 32'd1,        '0,           '0,       6'd5,  32'h0000_0000, 1'b0));
    vecs.push_back(mk(SUB,   32'd5,         32'd7,        '0,           '0,       6'd1,  32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(SRAI,  32'h8000_0000, '0,           32'h24,       '0,       6'd2,  32'hF800_0000, 1'b0));
    vecs.push_back(mk(SLTIU, 32'd1,         '0,           32'hFFFF_FFFF, '0,      6'd3,  32'd1,         1'b0));
    vecs.push_back(mk(SLT,   32'hFFFF_FFFF, 32'd1,        '0,           '0,       6'd4,  32'd1,         1'b0));
    vecs.push_back(mk(SLTU,  32'hFFFF_FFFF, 32'd1,        '0,           '0,       6'd6,  32'd0,         1'b0));
    vecs.push_back(mk(SLTI,  32'd3,         '0,           32'hFFFF_FFFF, '0,      6'd7,  32'd0,         1'b0));
    vecs.push_back(mk(XORI,  32'hF0F0_F0F0, '0,           32'hFFFF_FFFF, '0,      6'd8,  32'h0F0F_0F0F, 1'b0));
    vecs.push_back(mk(OR,    32'h0000_1200, 32'h0000_0034, '0,          '0,       6'd10, 32'h0000_1234, 1'b0));
    vecs.push_back(mk(ANDI,  32'h0000_1234, '0,           32'h0000_00FF, '0,      6'd11, 32'h0000_0034, 1'b0));
    vecs.push_back(mk(SLL,   32'd1,         32'h21,       '0,           '0,       6'd12, 32'd2,         1'b0));
    vecs.push_back(mk(SRL,   32'h8000_0000, 32'd31,       '0,           '0,       6'd13, 32'd1,         1'b0));
    vecs.push_back(mk(SRA,   32'h8000_0000, 32'd31,       '0,           '0,       6'd14, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(SLLI,  32'hFFFF_FFFF, '0,           32'd4,        '0,       6'd15, 32'hFFFF_FFF0, 1'b0));
    vecs.push_back(mk(LUI,   32'hDEAD_BEEF, '0,           32'h1234_5000, '0,      6'd16, 32'h1234_5000, 1'b0));
    vecs.push_back(mk(AUIPC, '0,            '0,           32'hFFFF_F000, 32'h1000, 6'd17, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(ADDI,  32'd7,         '0,           32'hFFFF_FFFF, '0,      6'd18, 32'd6,         1'b0));
    vecs.push_back(mk(LW,    32'd7,         32'd8,        32'd9,        '0,       6'd19, 32'd0,         1'b1));
    vecs.push_back(mk(ECALL, 32'd1,         32'd1,        32'd1,        '0,       6'd20, 32'd0,         1'b1));
`ifdef ALU_PIPE_MULDIV_EN
    vecs.push_back(mk(DIV,   32'h8000_0000, 32'hFFFF_FFFF, '0,          '0,       6'd21, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(REM,   32'h8000_0000, 32'hFFFF_FFFF, '0,          '0,       6'd22, 32'd0,         1'b0));
    vecs.push_back(mk(REMU,  32'd7,         32'd0,        '0,           '0,       6'd23, 32'd7,         1'b0));
    vecs.push_back(mk(DIVU,  32'd5,         32'd0,        '0,           '0,       6'd24, 32'hFFFF_FFFF, 1'b0));
`else
    vecs.push_back(mk(MUL,   32'd3,         32'd5,        '0,           '0,       6'd21, 32'd0,         1'b1));
    vecs.push_back(mk(DIV,   32'd9,         32'd3,        '0,           '0,       6'd22, 32'd0,         1'b1));
`endif

    // Applied back-to-back with out_ready high: one result per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].addr, vecs[i].tg);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_out_tag", i), 64'(out_tag), 64'(vecs[i].tg));
      chk($sformatf("vec%0d_out_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Back-pressure: result held, next op waits, then back-to-back
    out_ready = 1'b0;
    issue(ADD, 32'd2, 32'd3, '0, 6'd7);
    drive(SUB, 32'd10, 32'd1, '0, '0, 6'd8);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp%0d_result", c), 64'(result), 64'd5);
      chk($sformatf("bp%0d_out_tag", c), 64'(out_tag), 64'd7);
      chk($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    chk("b2b_result", 64'(result), 64'd9);
    chk("b2b_out_tag", 64'(out_tag), 64'd8);
    @(posedge clk); #1;
    chk("b2b_consumed", 64'(out_valid), 64'd0);

    // Flush beats out_ready and blocks a concurrent offer
    out_ready = 1'b0;
    issue(LW, '0, '0, '0, 6'd3);
    chk("fl_held_illegal", 64'(out_illegal), 64'd1);
    drive(ADD, 32'd1, 32'd2, '0, '0, 6'd4);
    flush = 1'b1; out_ready = 1'b1; #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_illegal", 64'(out_illegal), 64'd0);
    @(posedge clk); #1;
    chk("fl_not_accepted", 64'(out_valid), 64'd0);

`ifdef ALU_PIPE_MULDIV_EN
    run_iter("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_iter("mul",    MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    run_iter("mul_neg", MUL,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_iter("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_iter("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    run_iter("div",    DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_iter("rem",    REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_iter("divu",   DIVU,   32'd100,       32'd7,         32'd14);
    run_iter("remu",   REMU,   32'd100,       32'd7,         32'd2);

    // Flush during cycle 10 of a DIVU
    issue(DIVU, 32'd100, 32'd7, '0, 6'd1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("divflush_in_ready", 64'(in_ready), 64'd1);
    chk("divflush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("divflush_no_result", 64'(seen), 64'd0);

    // Reset in the middle of a multiply
    issue(MUL, 32'd3, 32'd5, '0, 6'd2);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mulrst_busy", 64'(busy), 64'd0);
    chk("mulrst_out_valid", 64'(out_valid), 64'd0);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mulrst_no_result", 64'(seen), 64'd0);
`endif

    // Unit still works after the corner cases
    issue(ADD, 32'd100, 32'd23, '0, 6'd33);
    chk("final_out_valid", 64'(out_valid), 64'd1);
    chk("final_result", 64'(result), 64'd123);
    chk("final_out_tag", 64'(out_tag), 64'd33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, handshaked integer execution unit for the mk_II out-of-order core: sits between a reservation station and the common data bus arbiter. Executes RV32I/RV64I register-register, register-immediate, LUI and AUIPC operations in one cycle and, when enabled, the M-extension multiply/divide operations iteratively over XLEN cycles. Carries a destination tag alongside each operation, holds its result under back-pressure and supports pipeline flush.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- TAG_WIDTH, 6, width of the destination/ROB tag carried with each operation
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of in-flight operation and held result
- in_valid  input  1  operation offered by reservation station
- in_ready  output  1  unit can accept an operation this cycle
- instr_name  input  instr_name_t  operation, enum from `structures`
- data_1, data_2  input  XLEN  source operands rs1, rs2
- immediate  input  XLEN  sign-extended immediate
- address  input  XLEN  instruction address (AUIPC)
- tag  input  TAG_WIDTH  destination tag
- out_valid  output  1  result held and offered
- out_ready  input  1  consumer takes result this cycle
- result  output  XLEN  result value
- out_tag  output  TAG_WIDTH  tag of the offered result
- out_illegal  output  1  offered result came from an unsupported instr_name
- busy  output  1  iterative operation in progress

## Operation
- FSM states: IDLE, ITER, FIX. ITER/FIX used only by multiply/divide.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
- Acceptance = in_valid && in_ready at a rising edge; operands, instr_name, tag captured.
- Single-cycle ops (ADD(I), SUB, SLT(I), SLT(I)U, XOR(I), OR(I), AND(I), SLL(I), SRL(I), SRA(I), LUI, AUIPC): result computed and registered at the acceptance edge; state stays IDLE.
- Shift amount = low $clog2(XLEN) bits of data_2 or immediate; SLL result truncated to XLEN bits; SRA arithmetic.
- SLT/SLTU results zero-extended to XLEN (value 0 or 1). All adds/subtracts wrap modulo 2^XLEN.
- Unsupported instr_name: result 0, out_illegal 1, single-cycle latency.
- MUL/MULH/MULHSU/MULHU: operands converted to magnitude with sign recorded per op signedness; shift-add, one bit per cycle over 2·XLEN-bit accumulator; FIX applies sign, selects low (MUL) or high half.
- DIV/DIVU/REM/REMU: restoring division, one quotient bit per cycle on magnitudes; FIX applies signs (quotient sign = XOR of operand signs, remainder sign = dividend sign).
- Divide by zero: quotient all ones, remainder = dividend; single-cycle, no ITER.
- Signed overflow (dividend = most negative, divisor = −1): quotient = dividend, remainder 0; single-cycle.
- Result hold: while out_valid && !out_ready, result, out_tag, out_illegal stable.
- out_valid clears on out_ready handshake unless a new result is written at the same edge (back-to-back).
- flush: clears out_valid, out_illegal, returns FSM to IDLE, aborts iteration; an offered in_valid that cycle is not accepted.

## Timing
- Reset values: out_valid 0, result 0, out_tag 0, out_illegal 0, busy 0, state IDLE; in_ready 1 after reset deasserts.
- Single-cycle ops and special-case divides: out_valid high the cycle after acceptance; throughput one per cycle with out_ready held high.
- Iterative ops: acceptance edge loads, ITER for XLEN edges, FIX one edge, result written at next edge; out_valid high XLEN+1 cycles after acceptance (33 for XLEN=32). busy high from cycle after acceptance until out_valid rises.
- in_ready low throughout ITER/FIX.
- Reset asserted mid-iteration: all state to reset values immediately, no result produced.
- Simultaneous flush and out_ready: flush wins, no new result written.

## Configuration
- ALU_PIPE_MULDIV_EN defined: multiply/divide datapath, ITER/FIX states, busy logic compiled in as above.
- Not defined: M-extension instr_name values treated as unsupported (result 0, out_illegal 1, one-cycle); FSM reduced to IDLE; busy tied 0.

## Test plan
- Reset mid-stream, then ADD data_1=0xFFFF_FFFF, data_2=1, tag=5 -> next cycle out_valid=1, result=0, out_tag=5.
- SRAI data_1=0x8000_0000, immediate=0x24 (amount 4) -> result 0xF800_0000; SLTIU data_1=1, immediate=0xFFFF_FFFF -> result 1.
- Back-pressure: ADD accepted, out_ready=0 for 3 cycles -> result stable, in_ready=0; out_ready=1 with next op pending -> back-to-back result next cycle.
- MULH data_1=0x8000_0000, data_2=0x8000_0000 (macro on) -> out_valid exactly 33 cycles after acceptance, result 0x4000_0000; MUL -> 0.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 in one cycle; REMU 7/0 -> 7; DIV −7/2 -> 0xFFFF_FFFD, REM -> 0xFFFF_FFFF.
- flush during cycle 10 of DIVU -> out_valid never rises, in_ready high next cycle; macro off, MUL -> out_illegal=1, result 0.
